// File: rtl/bram_pkg.sv
// Shared definitions for the true-dual-port lane RAM.
//   LANE_W     : bits per lane (8 data + 1 parity)
//   MAX_LANES  : widest supported word, used to size lane_merge
//   wmode_e    : per-port write-mode encoding
//   lane_merge : replace lanes of an old word with new data where we[i]=1
package bram_pkg;
  localparam int LANE_W    = 9;
  localparam int MAX_LANES = 8;
  localparam int MAX_W     = LANE_W * MAX_LANES;

  typedef enum logic [1:0] {
    WM_READ_FIRST  = 2'd0,
    WM_WRITE_FIRST = 2'd1,
    WM_NO_CHANGE   = 2'd2
  } wmode_e;

  // Sized for the widest word; callers zero-extend inputs and cast the
  // result back to their own word width.
  function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0]     old_w,
                                                  input logic [MAX_W-1:0]     new_w,
                                                  input logic [MAX_LANES-1:0] we);
    logic [MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_LANES; i++)
      if (we[i]) res[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
    return res;
  endfunction
endpackage

// File: rtl/bram_port_out.sv
// Output path of one RAM port: read latch, write-mode select, optional
// output register, SSR/SRVAL and reset handling.
//   clk_i, rst_i : shared clock, synchronous active-high reset
//   en_i         : port enable
//   we_any_i     : any lane write enable set this cycle
//   ssr_i        : synchronous set/reset of the output stage to SRVAL
//   regce_i      : output register enable (only used with DO_REG=1)
//   old_i        : array contents at this port's address before the edge
//   wf_i         : old_i with this port's written lanes replaced
//   do_o         : port output word (lane-packed)
module bram_port_out
  import bram_pkg::*;
#(
  parameter int             W      = 18,
  parameter wmode_e         MODE   = WM_READ_FIRST,
  parameter int             DO_REG = 0,
  parameter logic [W-1:0]   SRVAL  = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         we_any_i,
  input  logic         ssr_i,
  input  logic         regce_i,
  input  logic [W-1:0] old_i,
  input  logic [W-1:0] wf_i,
  output logic [W-1:0] do_o
);
  logic [W-1:0] latch_q, latch_d;

  always_comb begin
    latch_d = latch_q;
    if (en_i) begin
      // With an output register, SSR belongs to the register stage.
      if (DO_REG == 0 && ssr_i) latch_d = SRVAL;
      else begin
        case (MODE)
          WM_WRITE_FIRST: latch_d = wf_i;
          WM_NO_CHANGE:   if (!we_any_i) latch_d = old_i;
          default:        latch_d = old_i;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) latch_q <= SRVAL;
    else       latch_q <= latch_d;
  end

  if (DO_REG != 0) begin : g_reg
    logic [W-1:0] out_q;
    // Reset also overwrites the latch, so an in-flight read is lost.
    always_ff @(posedge clk_i) begin
      if (rst_i)        out_q <= SRVAL;
      else if (regce_i) out_q <= ssr_i ? SRVAL : latch_q;
    end
    assign do_o = out_q;
  end else begin : g_noreg
    logic unused_regce;
    assign unused_regce = regce_i;
    assign do_o = latch_q;
  end
endmodule

// File: rtl/bram_tdp_lanes.sv
// True-dual-port RAM with LANES 9-bit lanes (8 data + 1 parity), per-lane
// write enables, per-port write mode and optional output register.
//   CLK, RST              : shared clock, synchronous active-high reset
//   ENx, WEx, ADDRx       : port enable, per-lane write enable, address
//   DIx, DIPx             : write data / parity (lane i = {DIP[i], DI[8i+:8]})
//   SSRx, REGCEx          : output set/reset, output register enable
//   DOx, DOPx             : read data / parity
//   COLL_WW, COLL_RW      : registered one-cycle collision flags
module bram_tdp_lanes
  import bram_pkg::*;
#(
  parameter int                   LANES        = 2,
  parameter int                   ADDR_W       = 10,
  parameter string                WRITE_MODE_A = "READ_FIRST",
  parameter string                WRITE_MODE_B = "READ_FIRST",
  parameter int                   DO_REG       = 0,
  parameter logic [9*LANES-1:0]   SRVAL        = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENA,
  input  logic [LANES-1:0]     WEA,
  input  logic [ADDR_W-1:0]    ADDRA,
  input  logic [8*LANES-1:0]   DIA,
  input  logic [LANES-1:0]     DIPA,
  input  logic                 SSRA,
  input  logic                 REGCEA,
  output logic [8*LANES-1:0]   DOA,
  output logic [LANES-1:0]     DOPA,
  input  logic                 ENB,
  input  logic [LANES-1:0]     WEB,
  input  logic [ADDR_W-1:0]    ADDRB,
  input  logic [8*LANES-1:0]   DIB,
  input  logic [LANES-1:0]     DIPB,
  input  logic                 SSRB,
  input  logic                 REGCEB,
  output logic [8*LANES-1:0]   DOB,
  output logic [LANES-1:0]     DOPB,
  output logic                 COLL_WW,
  output logic                 COLL_RW
);
  localparam int W     = LANE_W * LANES;
  localparam int DEPTH = 1 << ADDR_W;

  localparam wmode_e MODE_A = (WRITE_MODE_A == "WRITE_FIRST") ? WM_WRITE_FIRST :
                              (WRITE_MODE_A == "NO_CHANGE")   ? WM_NO_CHANGE : WM_READ_FIRST;
  localparam wmode_e MODE_B = (WRITE_MODE_B == "WRITE_FIRST") ? WM_WRITE_FIRST :
                              (WRITE_MODE_B == "NO_CHANGE")   ? WM_NO_CHANGE : WM_READ_FIRST;

  logic [W-1:0] dia_w, dib_w, doa_w, dob_w;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign dia_w[i*LANE_W +: LANE_W] = {DIPA[i], DIA[i*8 +: 8]};
    assign dib_w[i*LANE_W +: LANE_W] = {DIPB[i], DIB[i*8 +: 8]};
    assign DOA[i*8 +: 8] = doa_w[i*LANE_W +: 8];
    assign DOPA[i]       = doa_w[i*LANE_W + 8];
    assign DOB[i*8 +: 8] = dob_w[i*LANE_W +: 8];
    assign DOPB[i]       = dob_w[i*LANE_W + 8];
  end

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] old_a, old_b, a_wf, b_wf, a_wr;
  logic         wr_a, wr_b, same_addr, ww_d, rw_d, ww_q, rw_q;

  assign old_a     = mem_q[ADDRA];
  assign old_b     = mem_q[ADDRB];
  assign wr_a      = ENA && (|WEA) && !RST;
  assign wr_b      = ENB && (|WEB) && !RST;
  assign same_addr = (ADDRA == ADDRB);

  assign a_wf = W'(lane_merge(MAX_W'(old_a), MAX_W'(dia_w), MAX_LANES'(WEA)));
  assign b_wf = W'(lane_merge(MAX_W'(old_b), MAX_W'(dib_w), MAX_LANES'(WEB)));
  // On a shared write address, A's lanes are laid over B's merged word so
  // overlapping lanes take A and the rest keep their own port's data.
  assign a_wr = W'(lane_merge(MAX_W'((wr_b && same_addr) ? b_wf : old_a),
                              MAX_W'(dia_w), MAX_LANES'(WEA)));

  always_ff @(posedge CLK) begin
    if (wr_b && !(wr_a && same_addr)) mem_q[ADDRB] <= b_wf;
    if (wr_a)                         mem_q[ADDRA] <= a_wr;
  end

  assign ww_d = wr_a && wr_b && same_addr && (|(WEA & WEB));
  assign rw_d = same_addr && ((wr_a && ENB && !(|WEB)) || (wr_b && ENA && !(|WEA)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      ww_q <= 1'b0;
      rw_q <= 1'b0;
    end else begin
      ww_q <= ww_d;
      rw_q <= rw_d;
    end
  end

  assign COLL_WW = ww_q;
  assign COLL_RW = rw_q;

  bram_port_out #(.W(W), .MODE(MODE_A), .DO_REG(DO_REG), .SRVAL(SRVAL)) u_pa (
    .clk_i(CLK), .rst_i(RST), .en_i(ENA), .we_any_i(|WEA), .ssr_i(SSRA),
    .regce_i(REGCEA), .old_i(old_a), .wf_i(a_wf), .do_o(doa_w)
  );

  bram_port_out #(.W(W), .MODE(MODE_B), .DO_REG(DO_REG), .SRVAL(SRVAL)) u_pb (
    .clk_i(CLK), .rst_i(RST), .en_i(ENB), .we_any_i(|WEB), .ssr_i(SSRB),
    .regce_i(REGCEB), .old_i(old_b), .wf_i(b_wf), .do_o(dob_w)
  );
endmodule

// File: tb/tb_bram_tdp_lanes.sv
// Three RAM instances share one stimulus stream: A=WRITE_FIRST/B=READ_FIRST,
// A=READ_FIRST/B=WRITE_FIRST (both unregistered), and A=NO_CHANGE with the
// output register. Expected words are written as {DOP, DO}.
module tb_bram_tdp_lanes;
  localparam logic [17:0] SRV = 18'h3FFFF;

  logic        clk = 1'b0;
  logic        rst, ena, enb, ssra, ssrb, regcea, regceb;
  logic [1:0]  wea, web, dipa, dipb;
  logic [3:0]  addra, addrb;
  logic [15:0] dia, dib;

  logic [15:0] doa_wf, dob_wf, doa_rf, dob_rf, doa_nc, dob_nc;
  logic [1:0]  dopa_wf, dopb_wf, dopa_rf, dopb_rf, dopa_nc, dopb_nc;
  logic        cww_wf, crw_wf, cww_rf, crw_rf, cww_nc, crw_nc;

  always #5 clk = ~clk;

  bram_tdp_lanes #(.LANES(2), .ADDR_W(4), .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST"),
                   .DO_REG(0), .SRVAL(SRV)) u_wf (
    .CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DIPA(dipa),
    .SSRA(ssra), .REGCEA(regcea), .DOA(doa_wf), .DOPA(dopa_wf),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DIPB(dipb),
    .SSRB(ssrb), .REGCEB(regceb), .DOB(dob_wf), .DOPB(dopb_wf),
    .COLL_WW(cww_wf), .COLL_RW(crw_wf));

  bram_tdp_lanes #(.LANES(2), .ADDR_W(4), .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
                   .DO_REG(0), .SRVAL(SRV)) u_rf (
    .CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DIPA(dipa),
    .SSRA(ssra), .REGCEA(regcea), .DOA(doa_rf), .DOPA(dopa_rf),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DIPB(dipb),
    .SSRB(ssrb), .REGCEB(regceb), .DOB(dob_rf), .DOPB(dopb_rf),
    .COLL_WW(cww_rf), .COLL_RW(crw_rf));

  bram_tdp_lanes #(.LANES(2), .ADDR_W(4), .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST"),
                   .DO_REG(1), .SRVAL(SRV)) u_nc (
    .CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DIPA(dipa),
    .SSRA(ssra), .REGCEA(regcea), .DOA(doa_nc), .DOPA(dopa_nc),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DIPB(dipb),
    .SSRB(ssrb), .REGCEB(regceb), .DOB(dob_nc), .DOPB(dopb_nc),
    .COLL_WW(cww_nc), .COLL_RW(crw_nc));

  typedef struct {
    logic        rst;
    logic        ena;  logic [1:0] wea; logic [3:0] addra; logic [17:0] da; logic ssra;
    logic        enb;  logic [1:0] web; logic [3:0] addrb; logic [17:0] db;
    logic [3:0]  chk;  // [0] wf.A  [1] wf.B  [2] rf.A  [3] collision flags
    logic [17:0] ea_wf, eb_wf, ea_rf;
    logic        eww, erw;
  } vec_t;

  localparam logic [3:0] WA = 4'b0001, WB = 4'b0010, RA = 4'b0100, CL = 4'b1000, ALL = 4'b1111;

  vec_t vt[$];
  int   n_chk = 0, n_pass = 0;

  function automatic vec_t mk(logic r, logic ea, logic [1:0] wa_, logic [3:0] aa, logic [17:0] da, logic sa,
                              logic eb, logic [1:0] wb_, logic [3:0] ab, logic [17:0] db,
                              logic [3:0] c, logic [17:0] xa, logic [17:0] xb, logic [17:0] xr,
                              logic xww, logic xrw);
    vec_t v;
    v.rst = r; v.ena = ea; v.wea = wa_; v.addra = aa; v.da = da; v.ssra = sa;
    v.enb = eb; v.web = wb_; v.addrb = ab; v.db = db;
    v.chk = c; v.ea_wf = xa; v.eb_wf = xb; v.ea_rf = xr; v.eww = xww; v.erw = xrw;
    return v;
  endfunction

  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // One cycle on the registered-output instance, port A only.
  task automatic nc(input logic r, input logic e, input logic [1:0] we, input logic [3:0] a,
                    input logic [17:0] d, input logic s, input logic rc,
                    input logic [17:0] exp, input string nm);
    rst = r; ena = e; wea = we; addra = a; dia = d[15:0]; dipa = d[17:16]; ssra = s; regcea = rc;
    enb = 1'b0; web = '0;
    @(posedge clk); #1;
    check(nm, {dopa_nc, doa_nc}, exp);
  endtask

  initial begin
    rst = 0; ena = 0; enb = 0; ssra = 0; ssrb = 0; regcea = 0; regceb = 0;
    wea = 0; web = 0; dipa = 0; dipb = 0; addra = 0; addrb = 0; dia = 0; dib = 0;

    //          rst ena wea addr data       ssr  enb web addr data      chk      wf.A      wf.B      rf.A      ww rw
    vt.push_back(mk(1, 0, 0, 0,  18'h0,     0,   0, 0, 0,  18'h0,      ALL,     SRV,      SRV,      SRV,      0, 0));
    vt.push_back(mk(0, 1, 3, 5,  18'h01234, 0,   0, 0, 0,  18'h0,      WA|WB|CL,18'h01234,SRV,      18'h0,    0, 0));
    vt.push_back(mk(0, 1, 0, 5,  18'h0,     0,   0, 0, 0,  18'h0,      WA|RA|CL,18'h01234,18'h0,    18'h01234,0, 0));
    vt.push_back(mk(0, 1, 3, 7,  18'h0AABB, 0,   0, 0, 0,  18'h0,      WA,      18'h0AABB,18'h0,    18'h0,    0, 0));
    vt.push_back(mk(0, 1, 1, 7,  18'h000CC, 0,   0, 0, 0,  18'h0,      WA|RA,   18'h0AACC,18'h0,    18'h0AABB,0, 0));
    vt.push_back(mk(0, 1, 0, 7,  18'h0,     0,   0, 0, 0,  18'h0,      WA|RA,   18'h0AACC,18'h0,    18'h0AACC,0, 0));
    vt.push_back(mk(0, 1, 3, 8,  18'h25A3C, 0,   0, 0, 0,  18'h0,      WA,      18'h25A3C,18'h0,    18'h0,    0, 0));
    vt.push_back(mk(0, 1, 0, 8,  18'h0,     0,   1, 1, 8,  18'h100FF,  ALL,     18'h25A3C,18'h25A3C,18'h25A3C,0, 1));
    vt.push_back(mk(0, 1, 0, 8,  18'h0,     0,   0, 0, 0,  18'h0,      WA|RA|CL,18'h35AFF,18'h0,    18'h35AFF,0, 0));
    vt.push_back(mk(0, 1, 3, 3,  18'h01111, 0,   1, 2, 3,  18'h02222,  WA|CL,   18'h01111,18'h0,    18'h0,    1, 0));
    vt.push_back(mk(0, 1, 0, 3,  18'h0,     0,   1, 0, 3,  18'h0,      ALL,     18'h01111,18'h01111,18'h01111,0, 0));
    vt.push_back(mk(0, 1, 1, 3,  18'h000AA, 0,   1, 2, 3,  18'h0BB00,  WA|WB|CL,18'h011AA,18'h01111,18'h0,    0, 0));
    vt.push_back(mk(0, 1, 0, 3,  18'h0,     0,   0, 0, 0,  18'h0,      WA|RA,   18'h0BBAA,18'h0,    18'h0BBAA,0, 0));
    vt.push_back(mk(0, 1, 2, 3,  18'h0CC00, 0,   1, 3, 3,  18'h0DDEE,  WA|CL,   18'h0CCAA,18'h0,    18'h0,    1, 0));
    vt.push_back(mk(0, 1, 0, 3,  18'h0,     0,   1, 0, 3,  18'h0,      ALL,     18'h0CCEE,18'h0CCEE,18'h0CCEE,0, 0));
    vt.push_back(mk(0, 1, 3, 9,  18'h00001, 0,   0, 0, 0,  18'h0,      WA,      18'h00001,18'h0,    18'h0,    0, 0));
    vt.push_back(mk(0, 1, 3, 9,  18'h05555, 0,   1, 0, 9,  18'h0,      ALL,     18'h05555,18'h00001,18'h00001,0, 1));
    vt.push_back(mk(0, 0, 0, 0,  18'h0,     0,   1, 0, 9,  18'h0,      WB|CL,   18'h0,    18'h05555,18'h0,    0, 0));
    vt.push_back(mk(0, 1, 0, 5,  18'h0,     1,   0, 0, 0,  18'h0,      WA|RA,   SRV,      18'h0,    SRV,      0, 0));
    vt.push_back(mk(0, 1, 3, 5,  18'h00077, 1,   0, 0, 0,  18'h0,      WA|RA,   SRV,      18'h0,    SRV,      0, 0));
    vt.push_back(mk(0, 1, 0, 5,  18'h0,     0,   0, 0, 0,  18'h0,      WA|RA,   18'h00077,18'h0,    18'h00077,0, 0));
    vt.push_back(mk(0, 0, 3, 5,  18'h0FFFF, 1,   0, 0, 0,  18'h0,      WA|RA,   18'h00077,18'h0,    18'h00077,0, 0));
    vt.push_back(mk(0, 1, 0, 5,  18'h0,     0,   0, 0, 0,  18'h0,      WA|RA,   18'h00077,18'h0,    18'h00077,0, 0));
    vt.push_back(mk(0, 1, 3, 15, 18'h10F0F, 0,   0, 0, 0,  18'h0,      WA,      18'h10F0F,18'h0,    18'h0,    0, 0));
    vt.push_back(mk(0, 0, 0, 0,  18'h0,     0,   1, 0, 15, 18'h0,      WB,      18'h0,    18'h10F0F,18'h0,    0, 0));
    vt.push_back(mk(0, 1, 0, 15, 18'h0,     0,   1, 0, 15, 18'h0,      ALL,     18'h10F0F,18'h10F0F,18'h10F0F,0, 0));
    vt.push_back(mk(1, 1, 3, 5,  18'h03333, 0,   0, 0, 0,  18'h0,      ALL,     SRV,      SRV,      SRV,      0, 0));
    vt.push_back(mk(0, 1, 0, 5,  18'h0,     0,   0, 0, 0,  18'h0,      WA|RA,   18'h00077,18'h0,    18'h00077,0, 0));

    for (int k = 0; k < vt.size(); k++) begin
      rst = vt[k].rst; ena = vt[k].ena; wea = vt[k].wea; addra = vt[k].addra;
      dia = vt[k].da[15:0]; dipa = vt[k].da[17:16]; ssra = vt[k].ssra; regcea = 1'b0;
      enb = vt[k].enb; web = vt[k].web; addrb = vt[k].addrb;
      dib = vt[k].db[15:0]; dipb = vt[k].db[17:16]; ssrb = 1'b0; regceb = 1'b0;
      @(posedge clk); #1;
      if (vt[k].chk[0]) check($sformatf("row%0d wf.DOA", k), {dopa_wf, doa_wf}, vt[k].ea_wf);
      if (vt[k].chk[1]) check($sformatf("row%0d wf.DOB", k), {dopb_wf, dob_wf}, vt[k].eb_wf);
      if (vt[k].chk[2]) check($sformatf("row%0d rf.DOA", k), {dopa_rf, doa_rf}, vt[k].ea_rf);
      if (vt[k].chk[3]) begin
        check($sformatf("row%0d COLL_WW", k), {17'b0, cww_wf}, {17'b0, vt[k].eww});
        check($sformatf("row%0d COLL_RW", k), {17'b0, crw_wf}, {17'b0, vt[k].erw});
      end
    end

    // Registered output, NO_CHANGE port A: latency, REGCE hold, SSR, mid-read reset.
    //  rst en we addr data       ssr rce  expected
    nc(1, 0, 0, 0, 18'h0,     0, 1, SRV,       "nc reset");
    nc(0, 1, 3, 2, 18'h0BEEF, 0, 1, SRV,       "nc write holds");
    nc(0, 1, 0, 2, 18'h0,     0, 1, SRV,       "nc read edge1");
    nc(0, 0, 0, 2, 18'h0,     0, 1, 18'h0BEEF, "nc read edge2");
    nc(0, 1, 3, 4, 18'h01234, 0, 0, 18'h0BEEF, "nc write rce0");
    nc(0, 1, 0, 4, 18'h0,     0, 1, 18'h0BEEF, "nc read4 edge1");
    nc(0, 0, 0, 4, 18'h0,     0, 0, 18'h0BEEF, "nc regce0 hold");
    nc(0, 0, 0, 4, 18'h0,     0, 1, 18'h01234, "nc regce1 load");
    nc(0, 1, 3, 4, 18'h09999, 0, 1, 18'h01234, "nc nochange wr");
    nc(0, 0, 0, 4, 18'h0,     0, 1, 18'h01234, "nc nochange hold");
    nc(0, 0, 0, 4, 18'h0,     1, 1, SRV,       "nc ssr");
    nc(0, 0, 0, 4, 18'h0,     0, 1, 18'h01234, "nc latch kept");
    nc(0, 1, 0, 2, 18'h0,     0, 0, 18'h01234, "nc mid read");
    nc(1, 0, 0, 2, 18'h0,     0, 0, SRV,       "nc mid reset");
    nc(0, 0, 0, 2, 18'h0,     0, 1, SRV,       "nc read dropped");
    nc(0, 0, 0, 2, 18'h0,     0, 1, SRV,       "nc read dropped2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bram_tdp_lanes.md
Name: bram_tdp_lanes

Overview:
- Parametrised true-dual-port block RAM, successor to the fixed 2-lane 18-bit dual-port wrappers.
- Generalised to N 9-bit lanes (8 data + 1 parity each) with per-lane write enables, per-port write mode and an optional output pipeline register.
- Both ports share one clock; same-cycle port collisions are resolved deterministically and flagged.
- Sits under the array/cache wrappers as the common RAM primitive for simulation and FPGA builds.

Parameters:
- LANES, 2, number of 9-bit lanes per word (1..8).
- ADDR_W, 10, address width; depth = 2**ADDR_W words.
- WRITE_MODE_A, "READ_FIRST", port A mode: "READ_FIRST" | "WRITE_FIRST" | "NO_CHANGE".
- WRITE_MODE_B, "READ_FIRST", port B mode, same encoding.
- DO_REG, 0, 1 adds an output register stage (read latency 2).
- SRVAL, 0, 9*LANES-bit value loaded into output stages by RST/SSR.

Ports:
- CLK  in  1  single clock, both ports
- RST  in  1  synchronous active-high reset
- ENA  in  1  port A enable
- WEA  in  LANES  port A per-lane write enable
- ADDRA  in  ADDR_W  port A address
- DIA  in  8*LANES  port A write data
- DIPA  in  LANES  port A write parity
- SSRA  in  1  port A synchronous output set/reset to SRVAL
- REGCEA  in  1  port A output-register clock enable (ignored when DO_REG=0)
- DOA  out  8*LANES  port A read data
- DOPA  out  LANES  port A read parity
- ENB, WEB, ADDRB, DIB, DIPB, SSRB, REGCEB, DOB, DOPB: same as port A, for port B
- COLL_WW  out  1  registered pulse: both ports wrote overlapping lanes of one address
- COLL_RW  out  1  registered pulse: one port wrote an address the other port read

Behaviour:
- Storage: 2**ADDR_W x 9*LANES bits. Lane i = {DIP[i], DI[8i+7:8i]}, and outputs use the same mapping.
- Memory contents are not reset and power up as X.
- Reset:
  - RST=1 loads every output latch and output register with SRVAL and clears COLL_WW/COLL_RW to 0.
  - RST suppresses all writes and reads in that cycle.
  - An in-flight DO_REG=1 read is discarded and never appears.
- Read latency: 1 cycle with DO_REG=0 (latch updates on the edge where EN=1); 2 cycles with DO_REG=1 (register loads from the latch on the edge where REGCE=1).
- EN=0: no write; the latch holds its value.
- SSR:
  - DO_REG=0: with EN=1 and SSR=1, the latch loads SRVAL; a write in the same cycle still occurs.
  - DO_REG=1: SSR acts on the output register (with REGCE=1) instead; the latch behaves normally.
- Write modes, applied per lane when EN=1 and WE[i]=1:
  - READ_FIRST: latch gets the old contents.
  - WRITE_FIRST: written lanes show the new data; unwritten lanes show the old data.
  - NO_CHANGE: the latch holds if any WE bit is set; a read happens only when WE=0.
- Write/write collision: ENA, ENB, same address, WEA&WEB != 0.
  - Overlapping lanes take port A data; non-overlapping lanes take their own port's data.
  - COLL_WW=1 the next cycle for one cycle.
- Read/write collision: one port writes an address and the other reads the same address (EN=1, its WE=0).
  - The reader gets the old contents.
  - COLL_RW=1 the next cycle.
  - WRITE_FIRST applies only to the writing port's own output.
- Both ports reading the same address: no flag.
- Addresses wrap naturally at 2**ADDR_W; there is no out-of-range case.

Decomposition:
- bram_pkg: LANE_W=9 constant, write-mode encoding constants, and a lane-merge function (old, new, we) -> word.
- Sub-module bram_port_out instantiated once per port: output latch, write-mode select, optional DO_REG stage, SSR/SRVAL and RST handling.
- Collision detection and the array stay in the top level.

Test Plan:
- Reset, DO_REG=0, SRVAL=0x3_FFFF (LANES=2): RST=1 for one edge -> DOA=0xFFFF, DOPA=2'b11, COLL_*=0. Next cycle write A addr 5 = 0x1234/00, then read addr 5 -> DOA=0x1234 one cycle after the read.
- Byte lanes: addr 7 holds 0xAABB; write A WEA=2'b01, DIA=0x00CC -> WRITE_FIRST DOA=0xAACC that cycle; READ_FIRST DOA=0xAABB; subsequent read 0xAACC.
- Write/write collision: A writes 0x1111 WEA=11 and B writes 0x2222 WEB=10, both to addr 3 -> mem[3]=0x1111, COLL_WW=1 for exactly one cycle.
- Read/write collision: A writes 0x5555 to addr 9 (old 0x0001) while B reads addr 9 -> DOB=0x0001, COLL_RW=1; B's next read of addr 9 returns 0x5555.
- DO_REG=1 pipeline: read addr 2 (0xBEEF) with REGCEA=1 -> DOA=0xBEEF two edges later. With REGCEA=0 on the second edge, DOA holds its prior value. SSRA=1 with REGCEA=1 -> DOA=SRVAL.
- NO_CHANGE and mid-op reset: NO_CHANGE port writes while DOA=0x1234 -> DOA stays 0x1234. With DO_REG=1, assert RST between the read edge and the register edge -> DOA=SRVAL and the read data never appears.
